// File: rtl/seq_divide_pkg.sv
// seq_divide_pkg: shared states, widths and sign helpers for the sequential divider
package seq_divide_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  localparam int DEF_BITS = 16;
  localparam int CNT_W = $clog2(DEF_BITS);
  localparam int MAX_BITS = 64;
  function automatic logic [MAX_BITS-1:0] cneg(input logic [MAX_BITS-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction
  function automatic logic [MAX_BITS-1:0] mag(input logic [MAX_BITS-1:0] x, input int bits);
    return cneg(x, x[bits-1]);
  endfunction
endpackage

// File: rtl/seq_divide_div_step.sv
// div_step: one combinational restoring shift-subtract step
module div_step #(parameter int BITS = 16) (
  input  logic [BITS:0]   i_part,
  input  logic [BITS-1:0] i_dmag,
  output logic [BITS-1:0] o_rem,
  output logic            o_q
);
  assign o_q = i_part >= {1'b0, i_dmag};
  assign o_rem = o_q ? BITS'(i_part - {1'b0, i_dmag}) : i_part[BITS-1:0];
endmodule

// File: rtl/seq_divide.sv
// seq_divide: signed truncating divider, one quotient bit per clock
module seq_divide
  import seq_divide_pkg::*;
#(parameter int BITS = 16) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [BITS-1:0] dividend,
  input  logic [BITS-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] quotient,
  output logic [BITS-1:0] remainder,
  output logic            div_by_zero
);
  localparam int CW = $clog2(BITS);
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [BITS-1:0] r_rem, r_dvd, r_dmag, w_rem;
  logic r_sq, r_sr, r_dz, w_q, w_dz_in;
  assign w_dz_in = divisor == '0;
  div_step #(.BITS(BITS)) u_step (
    .i_part({r_rem, r_dvd[BITS-1]}),
    .i_dmag(r_dmag),
    .o_rem (w_rem),
    .o_q   (w_q)
  );
  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  // next state: zero divisors skip straight to FIX
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = start ? (w_dz_in ? FIX : CALC) : IDLE;
      CALC:    w_next = r_cnt == '0 ? FIX : CALC;
      default: w_next = IDLE;
    endcase
  end
  // datapath: capture magnitudes, iterate, then sign-correct into the output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_dvd       <= '0;
      r_dmag      <= '0;
      r_sq        <= 1'b0;
      r_sr        <= 1'b0;
      r_dz        <= 1'b0;
    end else begin
      busy <= w_next != IDLE;
      done <= r_state == FIX;
      unique case (r_state)
        IDLE: if (start) begin
          r_dz   <= w_dz_in;
          r_sq   <= dividend[BITS-1] ^ divisor[BITS-1];
          r_sr   <= dividend[BITS-1];
          r_dvd  <= w_dz_in ? dividend : BITS'(mag(MAX_BITS'(dividend), BITS));
          r_dmag <= BITS'(mag(MAX_BITS'(divisor), BITS));
          r_rem  <= '0;
          r_cnt  <= CW'(BITS - 1);
        end
        CALC: begin
          r_rem <= w_rem;
          r_dvd <= {r_dvd[BITS-2:0], w_q};
          r_cnt <= r_cnt - 1'b1;
        end
        default: begin
          quotient    <= r_dz ? '1 : BITS'(cneg(MAX_BITS'(r_dvd), r_sq));
          remainder   <= r_dz ? r_dvd : BITS'(cneg(MAX_BITS'(r_rem), r_sr));
          div_by_zero <= r_dz;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divide.sv
// tb_seq_divide: table, corner-case and random checks of seq_divide
module tb_seq_divide;
  logic clk = 0, reset = 1, start = 0;
  logic [15:0] dividend = 0, divisor = 0;
  logic busy, done, div_by_zero;
  logic [15:0] quotient, remainder;
  int vectors = 0, miscompares = 0, overlap = 0;
  always #5 clk = ~clk;
  seq_divide #(.BITS(16)) dut (
    .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );
  always @(negedge clk) if (busy && done) overlap++;
  typedef struct {logic [15:0] a, b, q, r; logic dz;} vec_t;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] q, output logic [15:0] r, output logic dz);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    dz = b == 16'd0;
    if (dz) begin
      q = 16'hFFFF;
      r = a;
    end else begin
      q = 16'(sa / sb);
      r = 16'(sa % sb);
    end
  endfunction
  task automatic run(input logic [15:0] a, input logic [15:0] b, input bit now,
                     output int lat, output int bc);
    if (!now) @(negedge clk);
    dividend = a;
    divisor = b;
    start = 1;
    lat = -1;
    bc = 0;
    for (int i = 0; i <= 40; i++) begin
      @(negedge clk);
      if (i == 0) begin
        start = 0;
        dividend = 16'($urandom);
        divisor = 16'($urandom);
      end
      if (busy) bc++;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask
  task automatic do_check(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] q, input logic [15:0] r, input logic dz, input bit now);
    int lat, bc, el;
    run(a, b, now, lat, bc);
    el = dz ? 1 : 17;
    chk({tag, " latency"}, lat, el);
    chk({tag, " busy_cycles"}, bc, el);
    chk({tag, " quotient"}, {16'd0, quotient}, {16'd0, q});
    chk({tag, " remainder"}, {16'd0, remainder}, {16'd0, r});
    chk({tag, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, dz});
  endtask
  vec_t tbl[12];
  initial begin
    int lat;
    bit saw;
    logic [15:0] a, b, q, r;
    logic dz;
    tbl = '{
      '{16'd100, 16'd7, 16'd14, 16'd2, 1'b0},
      '{16'(-100), 16'd7, 16'hFFF2, 16'hFFFE, 1'b0},
      '{16'd100, 16'(-7), 16'hFFF2, 16'd2, 1'b0},
      '{16'(-100), 16'(-7), 16'd14, 16'hFFFE, 1'b0},
      '{16'h8000, 16'hFFFF, 16'h8000, 16'd0, 1'b0},
      '{16'h8000, 16'd1, 16'h8000, 16'd0, 1'b0},
      '{16'd0, 16'd5, 16'd0, 16'd0, 1'b0},
      '{16'd3, 16'd5, 16'd0, 16'd3, 1'b0},
      '{16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1},
      '{16'd100, 16'd7, 16'd14, 16'd2, 1'b0},
      '{16'h7FFF, 16'h8000, 16'd0, 16'h7FFF, 1'b0},
      '{16'h8000, 16'h8000, 16'd1, 16'd0, 1'b0}
    };
    repeat (3) @(negedge clk);
    chk("reset busy", {31'd0, busy}, 0);
    chk("reset done", {31'd0, done}, 0);
    chk("reset quotient", {16'd0, quotient}, 0);
    chk("reset remainder", {16'd0, remainder}, 0);
    chk("reset div_by_zero", {31'd0, div_by_zero}, 0);
    reset = 0;
    for (int i = 0; i < 12; i++)
      do_check($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dz, 0);
    @(negedge clk);
    dividend = 16'd1000;
    divisor = 16'd3;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    start = 1;
    dividend = 16'd7;
    divisor = 16'd1;
    @(negedge clk);
    start = 0;
    lat = -1;
    for (int i = 6; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
    end
    chk("ignored_start latency", lat, 17);
    chk("ignored_start quotient", {16'd0, quotient}, 333);
    chk("ignored_start remainder", {16'd0, remainder}, 1);
    do_check("start_on_done", 16'd9, 16'd2, 16'd4, 16'd1, 1'b0, 1);
    @(negedge clk);
    dividend = 16'd1000;
    divisor = 16'd3;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (7) @(negedge clk);
    reset = 1;
    #1;
    chk("abort busy", {31'd0, busy}, 0);
    chk("abort quotient", {16'd0, quotient}, 0);
    chk("abort remainder", {16'd0, remainder}, 0);
    chk("abort div_by_zero", {31'd0, div_by_zero}, 0);
    @(negedge clk);
    reset = 0;
    saw = 0;
    repeat (25) begin
      @(negedge clk);
      if (done || busy) saw = 1;
    end
    chk("abort no_done", {31'd0, saw}, 0);
    do_check("after_abort", 16'd9, 16'd2, 16'd4, 16'd1, 1'b0, 0);
    for (int n = 0; n < 150; n++) begin
      int sel;
      sel = $urandom_range(0, 5);
      a = 16'($urandom);
      b = sel == 0 ? 16'd0 : sel == 1 ? 16'($urandom_range(1, 9)) :
          sel == 2 ? 16'(-$urandom_range(1, 9)) : 16'($urandom);
      if (sel == 3) a = 16'h8000;
      model(a, b, q, r, dz);
      do_check($sformatf("rand%0d", n), a, b, q, r, dz, 0);
    end
    chk("busy_done_overlap", overlap, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
